router_fsm: RTL and testbench



---
 rtl/router_fsm_if.sv | 43 ++++
 rtl/router_fsm.sv | 112 +++++++++++
 tb/tb_router_fsm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/router_fsm_if.sv
// rtl/router_fsm_if.sv - handshake and phase-strobe bundle between packet source, FIFOs, register block and router_fsm
interface router_fsm_if #(
    parameter int WIDTH = 8
) ();
    logic             pkt_valid;
    logic [WIDTH-1:0] data_in;
    logic             fifo_full;
    logic             fifo_empty_0;
    logic             fifo_empty_1;
    logic             fifo_empty_2;
    logic             soft_reset_0;
    logic             soft_reset_1;
    logic             soft_reset_2;
    logic             parity_done;
    logic             low_pkt_valid;
    logic             write_enb_reg;
    logic             detect_add;
    logic             lfd_state;
    logic             ld_state;
    logic             laf_state;
    logic             full_state;
    logic             rst_int_reg;
    logic             busy;
    logic [1:0]       dest_addr;

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
        output full_state, rst_int_reg, busy, dest_addr
    );

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
        input  full_state, rst_int_reg, busy, dest_addr
    );
endinterface

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - packet-sequencing controller for the 1x3 router datapath
module router_fsm #(
    parameter int WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    router_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_dest_addr;
    logic [WIDTH-1:0] w_hdr;
    logic [1:0]       w_hdr_addr;
    logic             w_hdr_ok;
    logic             w_hdr_empty;
    logic             w_sel_empty;
    logic             w_sel_soft;
    logic             w_unused_hdr;

    assign w_hdr        = bus.data_in;
    assign w_hdr_addr   = w_hdr[1:0];
    assign w_unused_hdr = ^w_hdr[WIDTH-1:2];
    assign w_hdr_ok     = bus.pkt_valid && (w_hdr_addr != 2'd3);

    always_comb begin
        w_hdr_empty = 1'b0;
        case (w_hdr_addr)
            2'd0:    w_hdr_empty = bus.fifo_empty_0;
            2'd1:    w_hdr_empty = bus.fifo_empty_1;
            2'd2:    w_hdr_empty = bus.fifo_empty_2;
            default: w_hdr_empty = 1'b0;
        endcase
    end

    // Only the FIFO this packet is routed to may stall or abort it
    always_comb begin
        w_sel_empty = 1'b0;
        w_sel_soft  = 1'b0;
        case (r_dest_addr)
            2'd0: begin w_sel_empty = bus.fifo_empty_0; w_sel_soft = bus.soft_reset_0; end
            2'd1: begin w_sel_empty = bus.fifo_empty_1; w_sel_soft = bus.soft_reset_1; end
            2'd2: begin w_sel_empty = bus.fifo_empty_2; w_sel_soft = bus.soft_reset_2; end
            default: begin w_sel_empty = 1'b0; w_sel_soft = 1'b0; end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= DECODE_ADDRESS;
            r_dest_addr <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE_ADDRESS && w_hdr_ok) begin
                r_dest_addr <= w_hdr_addr;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state != DECODE_ADDRESS && w_sel_soft) begin
            w_next = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (w_hdr_ok) begin
                        w_next = w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY:    if (w_sel_empty) w_next = LOAD_FIRST_DATA;
                LOAD_FIRST_DATA:    w_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (bus.fifo_full)       w_next = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid) w_next = LOAD_PARITY;
                end
                FIFO_FULL_STATE:    if (!bus.fifo_full) w_next = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)        w_next = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid) w_next = LOAD_PARITY;
                    else                        w_next = LOAD_DATA;
                end
                LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: w_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default:            w_next = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        bus.detect_add    = (r_state == DECODE_ADDRESS);
        bus.lfd_state     = (r_state == LOAD_FIRST_DATA);
        bus.ld_state      = (r_state == LOAD_DATA);
        bus.laf_state     = (r_state == LOAD_AFTER_FULL);
        bus.full_state    = (r_state == FIFO_FULL_STATE);
        bus.rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
        bus.write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_AFTER_FULL)
                          || (r_state == LOAD_PARITY);
        bus.busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
        bus.dest_addr     = r_dest_addr;
    end
endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed and randomized checks of router_fsm against a packet-phase reference model
module tb_router_fsm;
    localparam int P_DA = 0, P_WTE = 1, P_LFD = 2, P_LD = 3, P_FFS = 4, P_LAF = 5, P_LP = 6, P_CPE = 7;

    logic clock;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   m_phase;
    logic [1:0] m_dest;

    router_fsm_if #(.WIDTH(8)) bus ();

    router_fsm #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe order: detect_add lfd ld laf full rst_int write_enb busy, then dest_addr
    function automatic logic [9:0] expect_vec(input int ph, input logic [1:0] d);
        logic [7:0] s;
        case (ph)
            P_DA:    s = 8'b1000_0000;
            P_WTE:   s = 8'b0000_0001;
            P_LFD:   s = 8'b0100_0001;
            P_LD:    s = 8'b0010_0010;
            P_FFS:   s = 8'b0000_1001;
            P_LAF:   s = 8'b0001_0011;
            P_LP:    s = 8'b0000_0011;
            default: s = 8'b0000_0101;
        endcase
        return {s, d};
    endfunction

    function automatic logic [9:0] observed();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
                bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.dest_addr};
    endfunction

    function automatic logic empty_of(input logic [1:0] a);
        logic [2:0] e;
        e = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
        return e[a];
    endfunction

    function automatic logic soft_of(input logic [1:0] a);
        logic [2:0] s;
        s = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
        return s[a];
    endfunction

    task automatic model_step();
        logic [1:0] a;
        a = bus.data_in[1:0];
        if (reset) begin
            m_phase = P_DA;
            m_dest  = 2'b00;
        end else if (m_phase != P_DA && soft_of(m_dest)) begin
            m_phase = P_DA;
        end else if (m_phase == P_DA) begin
            if (bus.pkt_valid && a != 2'd3) begin
                m_dest  = a;
                m_phase = empty_of(a) ? P_LFD : P_WTE;
            end
        end else if (m_phase == P_WTE) begin
            if (empty_of(m_dest)) m_phase = P_LFD;
        end else if (m_phase == P_LFD) begin
            m_phase = P_LD;
        end else if (m_phase == P_LD) begin
            if (bus.fifo_full)       m_phase = P_FFS;
            else if (!bus.pkt_valid) m_phase = P_LP;
        end else if (m_phase == P_FFS) begin
            if (!bus.fifo_full) m_phase = P_LAF;
        end else if (m_phase == P_LAF) begin
            m_phase = bus.parity_done ? P_DA : (bus.low_pkt_valid ? P_LP : P_LD);
        end else if (m_phase == P_LP) begin
            m_phase = P_CPE;
        end else begin
            m_phase = bus.fifo_full ? P_FFS : P_DA;
        end
    endtask

    task automatic check(input string tag, input logic [9:0] exp_v);
        logic [9:0] obs;
        obs = observed();
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check("model", expect_vec(m_phase, m_dest));
    endtask

    task automatic cycle_expect(input string tag, input int ph, input logic [1:0] d);
        cycle();
        check(tag, expect_vec(ph, d));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_phase  = P_DA;
        m_dest   = 2'b00;
        reset = 1'b1;
        bus.pkt_valid = 1'b0;    bus.data_in = 8'h00;    bus.fifo_full = 1'b0;
        bus.fifo_empty_0 = 1'b0; bus.fifo_empty_1 = 1'b0; bus.fifo_empty_2 = 1'b0;
        bus.soft_reset_0 = 1'b0; bus.soft_reset_1 = 1'b0; bus.soft_reset_2 = 1'b0;
        bus.parity_done = 1'b0;  bus.low_pkt_valid = 1'b0;

        cycle_expect("reset", P_DA, 2'd0);
        reset = 1'b0;

        bus.pkt_valid = 1'b1; bus.data_in = 8'h01; bus.fifo_empty_1 = 1'b1;
        cycle_expect("hdr1_lfd", P_LFD, 2'd1);
        bus.data_in = 8'hA6;
        cycle_expect("hdr1_ld", P_LD, 2'd1);
        bus.data_in = 8'h5B;
        cycle_expect("pay2_ld", P_LD, 2'd1);
        bus.data_in = 8'hC3;
        cycle_expect("pay3_ld", P_LD, 2'd1);
        bus.pkt_valid = 1'b0; bus.data_in = 8'h3C;
        cycle_expect("parity_lp", P_LP, 2'd1);
        cycle_expect("cpe", P_CPE, 2'd1);
        cycle_expect("cpe_to_da", P_DA, 2'd1);

        bus.pkt_valid = 1'b1; bus.data_in = 8'h41;
        cycle_expect("hdr1b_lfd", P_LFD, 2'd1);
        cycle_expect("hdr1b_ld", P_LD, 2'd1);
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) cycle_expect("ffs_hold", P_FFS, 2'd1);
        bus.fifo_full = 1'b0;
        cycle_expect("laf", P_LAF, 2'd1);
        cycle_expect("laf_to_ld", P_LD, 2'd1);

        bus.soft_reset_0 = 1'b1;
        cycle_expect("soft_other_ignored", P_LD, 2'd1);
        bus.soft_reset_0 = 1'b0; bus.soft_reset_1 = 1'b1;
        cycle_expect("soft_sel_da", P_DA, 2'd1);
        bus.soft_reset_1 = 1'b0;

        bus.data_in = 8'h03;
        cycle_expect("addr3_drop", P_DA, 2'd1);
        cycle_expect("addr3_drop2", P_DA, 2'd1);

        bus.data_in = 8'h02; bus.fifo_empty_2 = 1'b0;
        cycle_expect("wte_enter", P_WTE, 2'd2);
        for (int i = 0; i < 4; i++) cycle_expect("wte_hold", P_WTE, 2'd2);
        bus.fifo_empty_2 = 1'b1;
        cycle_expect("wte_to_lfd", P_LFD, 2'd2);
        cycle_expect("wte_ld", P_LD, 2'd2);
        bus.fifo_full = 1'b1;
        cycle_expect("ffs2", P_FFS, 2'd2);
        reset = 1'b1;
        cycle_expect("reset_in_ffs", P_DA, 2'd0);
        reset = 1'b0; bus.fifo_full = 1'b0;
        bus.data_in = 8'h00; bus.fifo_empty_0 = 1'b1;
        cycle_expect("post_reset_lfd", P_LFD, 2'd0);
        bus.pkt_valid = 1'b0;
        cycle_expect("post_reset_ld", P_LD, 2'd0);
        cycle_expect("post_reset_lp", P_LP, 2'd0);
        cycle_expect("post_reset_cpe", P_CPE, 2'd0);
        cycle_expect("post_reset_da", P_DA, 2'd0);

        for (int i = 0; i < 600; i++) begin
            reset             = ($urandom_range(0, 63) == 0);
            bus.pkt_valid     = ($urandom_range(0, 3) != 0);
            bus.data_in       = 8'($urandom);
            bus.fifo_full     = ($urandom_range(0, 3) == 0);
            bus.fifo_empty_0  = 1'($urandom);
            bus.fifo_empty_1  = 1'($urandom);
            bus.fifo_empty_2  = 1'($urandom);
            bus.soft_reset_0  = ($urandom_range(0, 15) == 0);
            bus.soft_reset_1  = ($urandom_range(0, 15) == 0);
            bus.soft_reset_2  = ($urandom_range(0, 15) == 0);
            bus.parity_done   = ($urandom_range(0, 3) == 0);
            bus.low_pkt_valid = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
